// File: rtl/apb_pkg.sv
// apb_pkg: shared APB direction/state types and the timer slave register map.
package apb_pkg;

   typedef enum logic {READ = 1'b0, WRITE = 1'b1} e_rw;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} e_apb_state;

   localparam logic [31:0] CTR_STATUS_ADDR = 32'd0;
   localparam logic [31:0] CTR_GOAL_ADDR   = 32'd1;
   localparam logic [31:0] CTR_CURR_ADDR   = 32'd2;

   localparam int CTR_STATUS_START = 0;
   localparam int CTR_STATUS_STOP  = 1;
   localparam int CTR_STATUS_STATE = 2;
   localparam int CTR_STATE_LEN    = 2;

   typedef enum logic [CTR_STATE_LEN-1:0] {CTR_IDLE, CTR_RUNNING, CTR_STOPPED, CTR_DONE} e_ctr_state;

endpackage

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB requester turning valid/ready commands
// into SETUP/ACCESS transfers with a wait-state timeout and a one-cycle response.
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int addrWidth     = 32,
   parameter int dataWidth     = 8,
   parameter int timeoutCycles = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [addrWidth-1:0] req_addr,
   input  logic [dataWidth-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [dataWidth-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 rsp_timeout,
   output logic [7:0]           err_count,
   output logic [addrWidth-1:0] paddr,
   output logic                 pwrite,
   output logic                 psel,
   output logic                 penable,
   output logic [dataWidth-1:0] pwdata,
   input  logic [dataWidth-1:0] prdata,
   input  logic                 pready,
   input  logic                 pslverr
);

   localparam int CW = timeoutCycles > 0 ? $clog2(timeoutCycles + 1) : 1;

   e_apb_state           state_q, state_d;
   logic [CW-1:0]        wait_q, wait_d;
   logic [addrWidth-1:0] paddr_q, paddr_d;
   logic                 pwrite_q, pwrite_d;
   logic [dataWidth-1:0] pwdata_q, pwdata_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 rsp_timeout_q, rsp_timeout_d;
   logic [7:0]           err_q, err_d;
   logic                 accept, done, expire;

   assign accept = req_valid && state_q == S_IDLE;
   assign done   = state_q == S_ACCESS && pready;
   // completion takes priority: expiry only counts while pready is low
   assign expire = state_q == S_ACCESS && !pready && timeoutCycles != 0 &&
                   wait_q + 1'b1 == CW'(timeoutCycles);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = accept ? S_SETUP :
                state_q == S_SETUP ? S_ACCESS :
                (done || expire) ? S_IDLE : state_q;
   end

   always_comb begin
      req_ready = state_q == S_IDLE;
      psel      = state_q != S_IDLE;
      penable   = state_q == S_ACCESS;
   end

   always_comb begin
      wait_d        = (state_q == S_ACCESS && !pready && !expire) ? wait_q + 1'b1 : '0;
      paddr_d       = accept ? req_addr : paddr_q;
      pwrite_d      = accept ? req_write : pwrite_q;
      pwdata_d      = accept ? req_wdata : pwdata_q;
      rsp_valid_d   = done || expire;
      rsp_rdata_d   = (done && !pwrite_q) ? prdata : rsp_valid_d ? '0 : rsp_rdata_q;
      rsp_err_d     = done ? pslverr : expire ? 1'b1 : rsp_err_q;
      rsp_timeout_d = done ? 1'b0 : expire ? 1'b1 : rsp_timeout_q;
      err_d         = (rsp_valid_d && rsp_err_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_q        <= '0;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         err_q         <= '0;
      end else begin
         wait_q        <= wait_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         err_q         <= err_d;
      end
   end

   assign paddr       = paddr_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign err_count   = err_q;

endmodule
